// File: rtl/shift_scheduler.sv
// shift_scheduler: round-robin front end that time-shares one barrel shifter
// between N requesters and returns tagged results on a valid/ready channel.
module shift_scheduler #(
    parameter int W   = 8,
    parameter int SAW = 3,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_data,
    input  logic [N*SAW-1:0] req_amt,
    input  logic [N*2-1:0]   req_op,
    output logic [W-1:0]     sh_in,
    output logic [SAW-1:0]   sh_amt,
    output logic             sh_dir,
    input  logic [W-1:0]     sh_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [IDW-1:0]   rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        PASS1,
        PASS2,
        RESP
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   data_q;
    logic [SAW-1:0] amt_q;
    logic [1:0]     op_q;
    logic [W-1:0]   acc_q;

    logic           found;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] gnt_nxt;
    logic [W-1:0]   sel_data;
    logic [SAW-1:0] sel_amt;
    logic [1:0]     sel_op;
    logic [SAW:0]   amt_cmp;

    // First valid requester at or after rr_ptr, wrapping, plus its operands
    always_comb begin
        found    = 1'b0;
        gnt      = '0;
        idx      = '0;
        sel_data = '0;
        sel_amt  = '0;
        sel_op   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % N);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == gnt) begin
                sel_data = req_data[i*W +: W];
                sel_amt  = req_amt[i*SAW +: SAW];
                sel_op   = req_op[i*2 +: 2];
            end
        end
    end

    assign gnt_nxt = (gnt == IDW'(N - 1)) ? '0 : gnt + IDW'(1);

    assign req_ready = (state == IDLE && found && !rst)
                     ? (N'(1) << gnt) : '0;

    assign busy = (state != IDLE);

    // Second rotate pass shifts the other way by the complementary amount
    assign amt_cmp = (SAW + 1)'(W) - {1'b0, amt_q};

    // Shifter operands are only driven during the two pass states
    always_comb begin
        sh_in  = '0;
        sh_amt = '0;
        sh_dir = 1'b0;
        case (state)
            PASS1: begin
                sh_in  = data_q;
                sh_amt = amt_q;
                sh_dir = op_q[0];
            end
            PASS2: begin
                sh_in  = data_q;
                sh_amt = amt_cmp[SAW-1:0];
                sh_dir = ~op_q[0];
            end
            default: begin
                sh_in  = '0;
                sh_amt = '0;
                sh_dir = 1'b0;
            end
        endcase
    end

    // Sequencer: grant, one or two shifter passes, then hold the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            data_q    <= '0;
            amt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        data_q <= sel_data;
                        amt_q  <= sel_amt;
                        op_q   <= sel_op;
                        id_q   <= gnt;
                        rr_ptr <= gnt_nxt;
                        state  <= PASS1;
                    end
                end
                PASS1: begin
                    acc_q <= sh_out;
                    if (!op_q[1] || amt_q == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= sh_out;
                        rsp_id    <= id_q;
                        state     <= RESP;
                    end else begin
                        state <= PASS2;
                    end
                end
                PASS2: begin
                    acc_q     <= acc_q | sh_out;
                    rsp_valid <= 1'b1;
                    rsp_data  <= acc_q | sh_out;
                    rsp_id    <= id_q;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: scoreboard bench with a cycle-level protocol model
// and a bit-permutation reference for the four shift/rotate ops.
module tb_shift_scheduler;

    localparam int W   = 8;
    localparam int SAW = 3;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_data;
    logic [N*SAW-1:0] req_amt;
    logic [N*2-1:0]   req_op;
    logic [W-1:0]     sh_in;
    logic [SAW-1:0]   sh_amt;
    logic             sh_dir;
    logic [W-1:0]     sh_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             busy;

    shift_scheduler #(.W(W), .SAW(SAW), .N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_op    (req_op),
        .sh_in     (sh_in),
        .sh_amt    (sh_amt),
        .sh_dir    (sh_dir),
        .sh_out    (sh_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // The shared zero-fill barrel shifter
    assign sh_out = sh_dir ? (sh_in >> sh_amt) : (sh_in << sh_amt);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    // Result as a permutation of operand bits
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] d,
                                            input int a,
                                            input logic [1:0] op);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            int j;
            j = 0;
            case (op)
                2'b00:   j = i + a;
                2'b01:   j = i - a;
                2'b10:   j = (i + a) % W;
                default: j = (i - a + W) % W;
            endcase
            if (j >= 0 && j < W) r[j] = d[i];
        end
        return r;
    endfunction

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    typedef struct {
        logic [W-1:0] d;
        int           id;
        int           due;
    } exp_t;

    exp_t         q[$];
    int           glog[$];
    int           cyc      = 0;
    bit           outst    = 0;
    int           acc_cyc  = 0;
    int           free_cyc = 0;
    int           ptr      = 0;
    logic [W-1:0] cur_d    = '0;
    int           cur_a    = 0;
    logic [1:0]   cur_op   = '0;
    bit           prev_pend = 0;
    logic [W-1:0] hold_d   = '0;
    logic [IDW-1:0] hold_id = '0;

    // Monitor: predicts ready/busy/shifter drive each cycle, scores responses
    always @(negedge clk) begin : mon
        int           g;
        logic [N-1:0] exp_rdy;
        bit           exp_busy;
        logic [W-1:0] e_in;
        int           e_amt;
        bit           e_dir;
        exp_t         e;
        cyc++;
        if (rst) begin
            chk("ready_in_reset", req_ready, 0);
            q.delete();
            outst     = 0;
            ptr       = 0;
            prev_pend = 0;
            free_cyc  = cyc + 1;
        end else begin
            exp_busy = outst && (cyc > acc_cyc);
            chk("busy", busy, exp_busy);
            e_in = '0; e_amt = 0; e_dir = 0;
            if (outst && cyc == acc_cyc + 1) begin
                e_in = cur_d; e_amt = cur_a; e_dir = cur_op[0];
            end else if (outst && cyc == acc_cyc + 2 &&
                         cur_op[1] && cur_a != 0) begin
                e_in = cur_d; e_amt = W - cur_a; e_dir = ~cur_op[0];
            end
            chk("sh_in", sh_in, e_in);
            chk("sh_amt", sh_amt, e_amt);
            chk("sh_dir", sh_dir, e_dir);
            g = rr_pick(ptr, req_valid);
            exp_rdy = '0;
            if (!outst && cyc >= free_cyc && g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if (rsp_valid) begin
                if (prev_pend) begin
                    chk("hold_data", rsp_data, hold_d);
                    chk("hold_id", rsp_id, hold_id);
                end else if (q.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    e = q.pop_front();
                    chk("rsp_data", rsp_data, e.d);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_cycle", cyc, e.due);
                    hold_d  = rsp_data;
                    hold_id = rsp_id;
                end
            end else if (prev_pend) begin
                fail("rsp_dropped");
            end
            prev_pend = rsp_valid && !rsp_ready;
            if (rsp_valid && rsp_ready) begin
                outst    = 0;
                free_cyc = cyc + 1;
            end
            if (exp_rdy != '0) begin
                cur_d  = req_data[g*W +: W];
                cur_a  = int'(req_amt[g*SAW +: SAW]);
                cur_op = req_op[g*2 +: 2];
                e.d    = ref_op(cur_d, cur_a, cur_op);
                e.id   = g;
                e.due  = cyc + ((cur_op[1] && cur_a != 0) ? 3 : 2);
                q.push_back(e);
                glog.push_back(g);
                outst   = 1;
                acc_cyc = cyc;
                ptr     = (g + 1) % N;
            end
        end
    end

    bit sticky = 0;

    // One cycle; requests that handshook are withdrawn unless sticky
    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (!sticky) req_valid = req_valid & ~hs;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] d,
                           input int a, input logic [1:0] op);
        req_data[i*W +: W]     = d;
        req_amt[i*SAW +: SAW]  = SAW'(a);
        req_op[i*2 +: 2]       = op;
        req_valid[i]           = 1'b1;
    endtask

    task automatic issue(input int i, input logic [W-1:0] d,
                         input int a, input logic [1:0] op);
        bit ok;
        ok = 0;
        set_req(i, d, a, op);
        for (int k = 0; k < 60; k++) begin
            step();
            if (!req_valid[i]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("issue_timeout");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (!outst && !rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("idle_timeout");
    endtask

    initial begin
        bit ok;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        repeat (3) step();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sh_in", sh_in, 0);
        rst = 1'b0;
        step();

        issue(0, 8'hB5, 3, 2'b00);
        wait_idle();
        issue(2, 8'h81, 1, 2'b11);
        wait_idle();
        issue(1, 8'h5A, 0, 2'b10);
        wait_idle();
        issue(3, 8'h96, 4, 2'b10);
        wait_idle();

        rst = 1'b1;
        step();
        rst = 1'b0;
        glog.delete();
        sticky = 1;
        for (int i = 0; i < N; i++)
            set_req(i, W'($urandom), i + 1, 2'(i % 2));
        ok = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (glog.size() >= 5) begin
                ok = 1;
                break;
            end
        end
        req_valid = '0;
        sticky = 0;
        if (!ok) fail("rr_timeout");
        for (int k = 0; k < 5 && k < glog.size(); k++)
            chk("rr_order", glog[k], k % N);
        wait_idle();
        glog.delete();
        issue(3, 8'hC3, 2, 2'b01);
        wait_idle();
        if (glog.size() > 0) chk("rr_only3", glog[0], 3);
        else fail("rr_only3");

        rsp_ready = 1'b0;
        issue(1, 8'h3C, 2, 2'b01);
        set_req(0, 8'h11, 5, 2'b11);
        repeat (8) step();
        chk("bp_busy", busy, 1);
        chk("bp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (!req_valid[0]) break;
        end
        wait_idle();

        glog.delete();
        issue(2, 8'h81, 3, 2'b11);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_valid", rsp_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_sh", {sh_in, sh_amt, sh_dir}, 0);
        glog.delete();
        set_req(3, 8'h0F, 1, 2'b00);
        set_req(0, 8'hF0, 1, 2'b01);
        for (int k = 0; k < 60; k++) begin
            step();
            if (req_valid == '0) break;
        end
        wait_idle();
        if (glog.size() > 0) chk("rstmid_first", glog[0], 0);
        else fail("rstmid_first");

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0)
                    set_req(i, W'($urandom), int'($urandom_range(W - 1)),
                            2'($urandom));
                else if (req_valid[i] && $urandom_range(31) == 0)
                    req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        if (q.size() != 0) fail("scoreboard_left");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
